// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer sequencers: default widths and the pooling FSM state type.
package cnn_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_MAPS_W = 8;
    localparam int unsigned DEF_SIZE_W = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        POOL   = 3'd2,
        WR_REQ = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } pool_seq_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Window counters and running read/write addresses for one 2x2/stride-2 pooling layer.
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned MAPS_W = DEF_MAPS_W,
    parameter int unsigned SIZE_W = DEF_SIZE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [MAPS_W-1:0] num_maps,
    input  logic [SIZE_W-1:0] map_size,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              last_window,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);

    logic [SIZE_W-1:0] x_q;
    logic [SIZE_W-1:0] y_q;
    logic [MAPS_W-1:0] m_q;
    logic [SIZE_W-1:0] size_q;
    logic [MAPS_W-1:0] maps_q;
    logic              x_end;
    logic              y_end;

    assign x_end       = (x_q == size_q - SIZE_W'(2));
    assign y_end       = (y_q == size_q - SIZE_W'(2));
    assign last_window = x_end && y_end && (m_q == maps_q - MAPS_W'(1));

    // Leaving a row (or a whole map) from the last window skips exactly S+2 input pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            size_q  <= '0;
            maps_q  <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
        end else if (load) begin
            x_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            size_q  <= map_size;
            maps_q  <= num_maps;
            rd_addr <= src_base;
            wr_addr <= dst_base;
        end else if (advance) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            if (!x_end) begin
                x_q     <= x_q + SIZE_W'(2);
                rd_addr <= rd_addr + ADDR_W'(2);
            end else begin
                x_q     <= '0;
                rd_addr <= rd_addr + ADDR_W'(size_q) + ADDR_W'(2);
                if (!y_end) begin
                    y_q <= y_q + SIZE_W'(2);
                end else begin
                    y_q <= '0;
                    m_q <= m_q + MAPS_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pool_layer_sequencer.sv
// Sequences one 2x2/stride-2 pooling layer: window reads, pooling handshake, result writes.
module pool_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned MAPS_W = DEF_MAPS_W,
    parameter int unsigned SIZE_W = DEF_SIZE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MAPS_W-1:0] num_maps,
    input  logic [SIZE_W-1:0] map_size,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              dma_start,
    output logic              dma_write,
    output logic [ADDR_W-1:0] dma_address,
    input  logic              dma_finish,
    output logic              pool_start,
    input  logic              pool_finish,
    output logic              busy,
    output logic              finish
);

    pool_seq_state_t   state;
    pool_seq_state_t   state_next;
    logic              cfg_ok_c;
    logic              load_c;
    logic              advance_c;
    logic              last_window;
    logic              last_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              dma_start_n;
    logic              dma_write_n;
    logic [ADDR_W-1:0] dma_address_n;
    logic              pool_start_n;
    logic              busy_n;
    logic              finish_n;

    assign cfg_ok_c  = (num_maps != '0) && (map_size >= SIZE_W'(2)) && !map_size[0];
    assign load_c    = (state == IDLE) && start;
    // Counters step as the write completes, so the next read address is ready in NEXT.
    assign advance_c = (state == WR_REQ) && dma_finish;

    pool_addr_gen #(
        .ADDR_W(ADDR_W),
        .MAPS_W(MAPS_W),
        .SIZE_W(SIZE_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (load_c),
        .advance    (advance_c),
        .num_maps   (num_maps),
        .map_size   (map_size),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .last_window(last_window),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr)
    );

    // Next state and the registered-output values for that state.
    always_comb begin
        state_next    = state;
        dma_address_n = dma_address;
        case (state)
            IDLE:    if (start) state_next = cfg_ok_c ? RD_REQ : DONE;
            RD_REQ:  if (dma_finish) state_next = POOL;
            POOL:    if (pool_finish) state_next = WR_REQ;
            WR_REQ:  if (dma_finish) state_next = NEXT;
            NEXT:    state_next = last_q ? DONE : RD_REQ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        dma_start_n  = (state_next == RD_REQ) || (state_next == WR_REQ);
        dma_write_n  = (state_next == WR_REQ);
        pool_start_n = (state_next == POOL);
        busy_n       = (state_next != IDLE);
        finish_n     = (state_next == DONE);
        // The first read address is taken straight from src_base since the generator loads on that edge.
        if (state_next == WR_REQ) begin
            dma_address_n = wr_addr;
        end else if (state_next == RD_REQ) begin
            dma_address_n = (state == IDLE) ? src_base : rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_q      <= 1'b0;
            dma_start   <= 1'b0;
            dma_write   <= 1'b0;
            dma_address <= '0;
            pool_start  <= 1'b0;
            busy        <= 1'b0;
            finish      <= 1'b0;
        end else begin
            state       <= state_next;
            dma_start   <= dma_start_n;
            dma_write   <= dma_write_n;
            dma_address <= dma_address_n;
            pool_start  <= pool_start_n;
            busy        <= busy_n;
            finish      <= finish_n;
            if (advance_c) begin
                last_q <= last_window;
            end
        end
    end

endmodule

// File: tb/tb_pool_layer_sequencer.sv
// Randomised bench for pool_layer_sequencer: DMA/pool responders log traffic, checked against an address model.
module tb_pool_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_maps = '0;
    logic [5:0]  map_size = '0;
    logic [15:0] src_base = '0;
    logic [15:0] dst_base = '0;
    logic        dma_start;
    logic        dma_write;
    logic [15:0] dma_address;
    logic        dma_finish = 1'b0;
    logic        pool_start;
    logic        pool_finish = 1'b0;
    logic        busy;
    logic        finish;

    int errors = 0;
    int checks = 0;
    int dma_lat_mode = 0;
    int pool_lat_mode = 0;
    bit stray_en = 0;
    bit junk_en = 0;
    bit seen_dma = 0;
    bit seen_pool = 0;
    int pool_cnt = 0;
    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];

    always #5 clk = ~clk;

    pool_layer_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_maps   (num_maps),
        .map_size   (map_size),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .dma_start  (dma_start),
        .dma_write  (dma_write),
        .dma_address(dma_address),
        .dma_finish (dma_finish),
        .pool_start (pool_start),
        .pool_finish(pool_finish),
        .busy       (busy),
        .finish     (finish)
    );

    // DMA model: acks after a latency, logs each transfer and checks request stability.
    initial begin : dma_resp
        int dcnt;
        int lat;
        logic [15:0] a0;
        logic w0;
        dcnt = 0; lat = 0; a0 = '0; w0 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (dma_finish) begin
                dma_finish = 1'b0;
                dcnt = 0;
                checks++;
                if (dma_start !== 1'b0) begin
                    errors++;
                    $display("FAIL dma_drop: dma_start=%0b after ack, required 0", dma_start);
                end
            end else if (dma_start) begin
                seen_dma = 1;
                if (dcnt == 0) begin
                    a0 = dma_address;
                    w0 = dma_write;
                    lat = (dma_lat_mode < 0) ? int'($urandom_range(0, 3)) : dma_lat_mode;
                end else begin
                    checks++;
                    if (dma_address !== a0 || dma_write !== w0) begin
                        errors++;
                        $display("FAIL dma_hold: addr=%0d wr=%0b, required addr=%0d wr=%0b",
                                 dma_address, dma_write, a0, w0);
                    end
                end
                if (dcnt >= lat) begin
                    dma_finish = 1'b1;
                    if (w0) wr_q.push_back(a0);
                    else    rd_q.push_back(a0);
                end else begin
                    dcnt++;
                end
            end else begin
                dcnt = 0;
            end
        end
    end

    // Pooling unit model, plus optional stray pool_finish pulses while a read is pending.
    initial begin : pool_resp
        int pcnt;
        int lat;
        pcnt = 0; lat = 0;
        forever begin
            @(posedge clk); #1;
            if (pool_finish) begin
                pool_finish = 1'b0;
                pcnt = 0;
            end else if (pool_start) begin
                seen_pool = 1;
                checks++;
                if (dma_start !== 1'b0) begin
                    errors++;
                    $display("FAIL overlap: dma_start=%0b during pool_start, required 0", dma_start);
                end
                if (pcnt == 0)
                    lat = (pool_lat_mode < 0) ? int'($urandom_range(0, 3)) : pool_lat_mode;
                if (pcnt >= lat) begin
                    pool_finish = 1'b1;
                    pool_cnt++;
                end else begin
                    pcnt++;
                end
            end else begin
                pcnt = 0;
                if (stray_en && dma_start && !dma_write && ($urandom_range(0, 1) == 1))
                    pool_finish = 1'b1;
            end
        end
    end

    task automatic run_layer(input int nm, input int s, input int src, input int dst,
                             input int exp_cyc, input string name);
        logic [15:0] exp_rd[$];
        logic [15:0] exp_wr[$];
        int n_win;
        int cyc;
        int fin_cnt;
        int fin_cyc;
        int budget;
        int n;
        n_win = 0;
        if (nm > 0 && s >= 2 && (s % 2) == 0) begin
            for (int m = 0; m < nm; m++)
                for (int y = 0; y < s; y += 2)
                    for (int x = 0; x < s; x += 2) begin
                        exp_rd.push_back(16'(src + m * s * s + y * s + x));
                        exp_wr.push_back(16'(dst + m * (s / 2) * (s / 2) + (y / 2) * (s / 2) + x / 2));
                        n_win++;
                    end
        end
        rd_q.delete(); wr_q.delete();
        pool_cnt = 0; seen_dma = 0; seen_pool = 0;
        budget = 20 * n_win + 50;

        @(posedge clk); #1;
        num_maps = 8'(nm); map_size = 6'(s); src_base = 16'(src); dst_base = 16'(dst);
        start = 1'b1;
        cyc = 0; fin_cnt = 0; fin_cyc = -1;
        while (cyc < budget && fin_cnt == 0) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_rise: busy=%0b, required 1", name, busy);
                end
            end
            if (junk_en) begin
                start = 1'($urandom_range(0, 1));
                num_maps = 8'($urandom); map_size = 6'($urandom);
                src_base = 16'($urandom); dst_base = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            if (finish) begin
                fin_cnt++;
                fin_cyc = cyc;
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (fin_cnt != 1) begin
            errors++;
            $display("FAIL %s finish_timeout: finish pulses=%0d within %0d cycles, required 1", name, fin_cnt, budget);
        end
        if (exp_cyc >= 0) begin
            checks++;
            if (fin_cyc != exp_cyc) begin
                errors++;
                $display("FAIL %s latency: finish at cycle %0d, required %0d", name, fin_cyc, exp_cyc);
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (finish !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done: finish=%0b busy=%0b, required 0 0", name, finish, busy);
            end
        end
        checks++;
        if (rd_q.size() != exp_rd.size() || wr_q.size() != exp_wr.size() || pool_cnt != n_win) begin
            errors++;
            $display("FAIL %s counts: reads=%0d writes=%0d pools=%0d, required %0d %0d %0d",
                     name, rd_q.size(), wr_q.size(), pool_cnt, exp_rd.size(), exp_wr.size(), n_win);
        end
        n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (rd_q[i] !== exp_rd[i]) begin
                errors++;
                $display("FAIL %s rd_addr[%0d]: got %0d, required %0d", name, i, rd_q[i], exp_rd[i]);
            end
        end
        n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (wr_q[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL %s wr_addr[%0d]: got %0d, required %0d", name, i, wr_q[i], exp_wr[i]);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (dma_start !== 1'b0 || dma_write !== 1'b0 || dma_address !== 16'd0 ||
            pool_start !== 1'b0 || busy !== 1'b0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL %s: dma_start=%0b dma_write=%0b dma_address=%0d pool_start=%0b busy=%0b finish=%0b, required all 0",
                     name, dma_start, dma_write, dma_address, pool_start, busy, finish);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_single_map();
        dma_lat_mode = 0; pool_lat_mode = 0;
        run_layer(1, 4, 0, 1000, 17, "single_map");
    endtask

    task automatic test_two_maps();
        dma_lat_mode = 0; pool_lat_mode = 0;
        run_layer(2, 2, 100, 500, 9, "two_maps");
    endtask

    task automatic test_degenerate();
        int cfg_nm[3] = '{0, 3, 2};
        int cfg_s[3]  = '{4, 3, 0};
        for (int i = 0; i < 3; i++) begin
            run_layer(cfg_nm[i], cfg_s[i], 50, 60, 1, "degenerate");
            checks++;
            if (seen_dma || seen_pool) begin
                errors++;
                $display("FAIL degenerate_activity: dma=%0b pool=%0b, required 0 0", seen_dma, seen_pool);
            end
        end
    endtask

    task automatic test_dma_delay();
        dma_lat_mode = 5; pool_lat_mode = 1;
        run_layer(1, 4, 300, 700, -1, "dma_delay");
    endtask

    task automatic test_reset_mid();
        int wait_cyc;
        dma_lat_mode = 0; pool_lat_mode = 3;
        @(posedge clk); #1;
        num_maps = 8'd2; map_size = 6'd4; src_base = 16'd10; dst_base = 16'd20;
        start = 1'b1;
        wait_cyc = 0;
        while (wait_cyc < 50 && pool_start !== 1'b1) begin
            @(posedge clk); #1;
            start = 1'b0;
            wait_cyc++;
        end
        checks++;
        if (pool_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wait: pool_start=%0b, required 1 within 50 cycles", pool_start);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_mid");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        pool_lat_mode = 0;
        run_layer(2, 4, 10, 20, 33, "after_reset");
    endtask

    task automatic test_back_to_back();
        int nm;
        int s;
        dma_lat_mode = -1; pool_lat_mode = -1;
        stray_en = 1; junk_en = 1;
        for (int i = 0; i < 8; i++) begin
            nm = int'($urandom_range(1, 3));
            s = 2 * int'($urandom_range(1, 8));
            run_layer(nm, s, (i == 0) ? 16'hFFF0 : int'($urandom_range(0, 65535)),
                      int'($urandom_range(0, 65535)), -1, "back_to_back");
        end
        stray_en = 0; junk_en = 0;
    endtask

    initial begin
        test_reset();
        test_single_map();
        test_two_maps();
        test_degenerate();
        test_dma_delay();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
